// File: rtl/redmule_castin_arbiter.sv
// Round-robin arbiter sharing one fixed-latency cast datapath between streamer channels,
// returning results in issue order through a credit-protected FIFO.
// Optional statistics counters: define REDMULE_CASTIN_ARB_STATS_EN.
//
// state  | meaning
// IDLE   | not issuing, waiting for enable_i
// ACTIVE | issuing one beat per cycle while credit is available
// DRAIN  | issuing stopped, waiting for in-flight beats and FIFO to empty
module redmule_castin_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DW         = 288,
  parameter int PIPE_LAT   = 1,
  parameter int FIFO_DEPTH = PIPE_LAT + 2,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 enable_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic [NUM_REQ*DW-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_cast_i,
  input  logic [NUM_REQ*3-1:0] req_fmt_i,
  output logic [DW-1:0]        cast_data_o,
  output logic                 cast_en_o,
  output logic [2:0]           cast_fmt_o,
  input  logic [DW-1:0]        cast_result_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DW-1:0]        rsp_data_o,
  output logic [IDW-1:0]       rsp_id_o,
  output logic                 idle_o
`ifdef REDMULE_CASTIN_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0] grant_cnt_o,
  output logic [31:0]           stall_cnt_o
`endif
);

  localparam int LAT1 = (PIPE_LAT > 0) ? PIPE_LAT : 1;
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

  state_e          state;
  logic [IDW-1:0]  ptr;
  logic [LAT1-1:0] tag_vld, tag_vld_nxt;
  logic [IDW-1:0]  tag_id [LAT1];
  logic [DW-1:0]   fifo_data [FIFO_DEPTH];
  logic [IDW-1:0]  fifo_id [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_cnt, fifo_cnt_nxt;
  logic            idle_q, idle_nxt;

  int              inflight;
  logic            credit, any_valid, issue, grant_found;
  logic [IDW-1:0]  grant_id;
  logic            push_vld, pop;
  logic [IDW-1:0]  push_id;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    inflight = 0;
    for (int i = 0; i < LAT1; i++) inflight += int'(tag_vld[i]);
  end

  // Same-cycle pop is ignored in the credit check, trading a bubble for a short path.
  assign credit    = (int'(fifo_cnt) + inflight + 1) <= FIFO_DEPTH;
  assign any_valid = |req_valid_i;
  assign issue     = rst_ni && !clear_i && (state == ACTIVE) && enable_i && any_valid && credit;

  always_comb begin
    grant_id    = '0;
    grant_found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!grant_found && req_valid_i[(int'(ptr) + i) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_id    = IDW'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    cast_data_o = '0;
    cast_en_o   = 1'b0;
    cast_fmt_o  = '0;
    if (issue) begin
      req_ready_o[grant_id] = 1'b1;
      cast_data_o           = req_data_i[int'(grant_id)*DW +: DW];
      cast_en_o             = req_cast_i[grant_id];
      cast_fmt_o            = req_fmt_i[int'(grant_id)*3 +: 3];
    end
  end

  always_comb begin
    if (PIPE_LAT == 0) begin
      push_vld = issue;
      push_id  = grant_id;
    end else begin
      push_vld = tag_vld[LAT1-1] && !clear_i;
      push_id  = tag_id[LAT1-1];
    end
  end

  assign pop = (fifo_cnt != '0) && rsp_ready_i && !clear_i;

  always_comb begin
    tag_vld_nxt = '0;
    if (PIPE_LAT > 0 && !clear_i) begin
      tag_vld_nxt[0] = issue;
      for (int i = 1; i < LAT1; i++) tag_vld_nxt[i] = tag_vld[i-1];
    end
  end

  assign fifo_cnt_nxt = clear_i ? '0 : fifo_cnt + CW'(push_vld) - CW'(pop);
  assign idle_nxt     = (tag_vld_nxt == '0) && (fifo_cnt_nxt == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      ptr      <= IDW'(NUM_REQ - 1);
      tag_vld  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      idle_q   <= 1'b1;
    end else begin
      tag_vld  <= tag_vld_nxt;
      fifo_cnt <= fifo_cnt_nxt;
      idle_q   <= idle_nxt;
      if (clear_i) begin
        state  <= IDLE;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (issue)    ptr    <= grant_id;
        if (push_vld) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)      rd_ptr <= ptr_inc(rd_ptr);
        case (state)
          IDLE:    if (enable_i) state <= ACTIVE;
          ACTIVE:  if (!enable_i) state <= DRAIN;
          DRAIN: begin
            if (enable_i)                           state <= ACTIVE;
            else if (inflight == 0 && fifo_cnt == '0) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Tags and FIFO payload carry no reset; validity lives in tag_vld and fifo_cnt.
  always_ff @(posedge clk_i) begin
    tag_id[0] <= grant_id;
    for (int i = 1; i < LAT1; i++) tag_id[i] <= tag_id[i-1];
    if (push_vld) begin
      fifo_data[wr_ptr] <= cast_result_i;
      fifo_id[wr_ptr]   <= push_id;
    end
  end

  always @(posedge clk_i) begin
    if (rst_ni && !clear_i)
      assert (!(push_vld && !pop && fifo_cnt == CW'(FIFO_DEPTH)));
  end

  assign rsp_valid_o = (fifo_cnt != '0);
  assign rsp_data_o  = rsp_valid_o ? fifo_data[rd_ptr] : '0;
  assign rsp_id_o    = rsp_valid_o ? fifo_id[rd_ptr] : '0;
  assign idle_o      = idle_q;

`ifdef REDMULE_CASTIN_ARB_STATS_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      grant_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (issue && grant_id == IDW'(r) && grant_cnt_o[r*32 +: 32] != '1)
          grant_cnt_o[r*32 +: 32] <= grant_cnt_o[r*32 +: 32] + 32'd1;
      end
      if (state == ACTIVE && any_valid && !credit && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_redmule_castin_arbiter.sv
// Directed bench for redmule_castin_arbiter (NUM_REQ=3, PIPE_LAT=1, FIFO_DEPTH=3).
// Cast datapath model: one register stage, inverts the beat when cast enable is set.
module tb_redmule_castin_arbiter;
  localparam int NUM_REQ = 3;
  localparam int DW      = 288;
  localparam int IDW     = 2;

  logic                  clk = 1'b0;
  logic                  rst_ni, clear_i, enable_i, rsp_ready_i;
  logic [NUM_REQ-1:0]    req_valid_i, req_ready_o, req_cast_i;
  logic [NUM_REQ*DW-1:0] req_data_i;
  logic [NUM_REQ*3-1:0]  req_fmt_i;
  logic [DW-1:0]         cast_data_o, cast_result_i, rsp_data_o;
  logic                  cast_en_o, rsp_valid_o, idle_o;
  logic [2:0]            cast_fmt_o;
  logic [IDW-1:0]        rsp_id_o;

  logic [DW-1:0]         d [NUM_REQ];
  int                    checks = 0;
  int                    failures = 0;

  always #5 clk = ~clk;

  always_comb for (int r = 0; r < NUM_REQ; r++) req_data_i[r*DW +: DW] = d[r];

  always @(posedge clk) cast_result_i <= cast_en_o ? ~cast_data_o : cast_data_o;

  redmule_castin_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
    .req_cast_i(req_cast_i), .req_fmt_i(req_fmt_i), .cast_data_o(cast_data_o),
    .cast_en_o(cast_en_o), .cast_fmt_o(cast_fmt_o), .cast_result_i(cast_result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_id_o(rsp_id_o), .idle_o(idle_o)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_n(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_outputs(input string tag);
    check_n({tag, "_ready"}, 32'(req_ready_o), 0);
    check_n({tag, "_rsp_valid"}, 32'(rsp_valid_o), 0);
    check_n({tag, "_idle"}, 32'(idle_o), 1);
    check({tag, "_cast_data"}, cast_data_o, '0);
    check_n({tag, "_cast_en"}, 32'(cast_en_o), 0);
    check_n({tag, "_cast_fmt"}, 32'(cast_fmt_o), 0);
    check({tag, "_rsp_data"}, rsp_data_o, '0);
    check_n({tag, "_rsp_id"}, 32'(rsp_id_o), 0);
  endtask

  initial begin
    logic [DW-1:0] ab;
    rst_ni = 1'b0; clear_i = 1'b0; enable_i = 1'b0; rsp_ready_i = 1'b0;
    req_valid_i = '0; req_cast_i = '0; req_fmt_i = '0;
    for (int r = 0; r < NUM_REQ; r++) d[r] = {9{32'hD000_0000 | 32'(r + 1)}};

    // Reset values
    cyc(); cyc();
    rst_ni = 1'b1;
    @(negedge clk);
    reset_outputs("rst");

    // Round robin with all requesters valid
    cyc();
    enable_i = 1'b1; rsp_ready_i = 1'b1;
    @(negedge clk);
    check_n("rr_idle_state_ready", 32'(req_ready_o), 0);
    for (int k = 1; k <= 9; k++) begin
      cyc();
      req_valid_i = (k <= 6) ? 3'b111 : 3'b000;
      @(negedge clk);
      check_n("rr_ready", 32'(req_ready_o), (k <= 6) ? (1 << ((k - 1) % 3)) : 0);
      if (k <= 6) check("rr_cast_data", cast_data_o, d[(k - 1) % 3]);
      check_n("rr_rsp_valid", 32'(rsp_valid_o), (k >= 3 && k <= 8) ? 1 : 0);
      if (k >= 3 && k <= 8) begin
        check_n("rr_rsp_id", 32'(rsp_id_o), (k - 3) % 3);
        check("rr_rsp_data", rsp_data_o, d[(k - 3) % 3]);
      end
    end
    check_n("rr_idle_after", 32'(idle_o), 1);

    // Single requester 2, passthrough
    cyc();
    ab = {36{8'hAB}};
    d[2] = ab;
    req_valid_i = 3'b100;
    @(negedge clk);
    check_n("r2_ready", 32'(req_ready_o), 3'b100);
    check("r2_cast_data", cast_data_o, ab);
    check_n("r2_cast_en", 32'(cast_en_o), 0);
    cyc();
    req_valid_i = '0;
    cyc();
    @(negedge clk);
    check_n("r2_rsp_valid", 32'(rsp_valid_o), 1);
    check_n("r2_rsp_id", 32'(rsp_id_o), 2);
    check("r2_rsp_data", rsp_data_o, ab);

    // Requester 1 with cast enabled
    cyc();
    req_valid_i = 3'b010; req_cast_i = 3'b010; req_fmt_i = 9'b000_101_000;
    @(negedge clk);
    check_n("r1_ready", 32'(req_ready_o), 3'b010);
    check_n("r1_cast_en", 32'(cast_en_o), 1);
    check_n("r1_cast_fmt", 32'(cast_fmt_o), 5);
    cyc();
    req_valid_i = '0; req_cast_i = '0; req_fmt_i = '0;
    cyc();
    @(negedge clk);
    check_n("r1_rsp_id", 32'(rsp_id_o), 1);
    check("r1_rsp_data", rsp_data_o, ~d[1]);

    // Backpressure: FIFO fills after exactly 3 issues, then resumes
    cyc();
    rsp_ready_i = 1'b0; req_valid_i = 3'b001;
    for (int e = 1; e <= 10; e++) begin
      if (e > 1) cyc();
      if (e == 7) rsp_ready_i = 1'b1;
      @(negedge clk);
      check_n("bp_ready", 32'(req_ready_o), (e <= 3 || e >= 8) ? 1 : 0);
      check_n("bp_rsp_valid", 32'(rsp_valid_o), (e >= 3) ? 1 : 0);
      if (e >= 3) check_n("bp_rsp_id", 32'(rsp_id_o), 0);
    end

    // enable drops with one beat in flight
    cyc();
    enable_i = 1'b0;
    @(negedge clk);
    check_n("dr_ready_e11", 32'(req_ready_o), 0);
    check_n("dr_rsp_valid_e11", 32'(rsp_valid_o), 1);
    cyc();
    @(negedge clk);
    check_n("dr_ready_e12", 32'(req_ready_o), 0);
    check_n("dr_rsp_valid_e12", 32'(rsp_valid_o), 1);
    check_n("dr_idle_e12", 32'(idle_o), 0);
    cyc();
    @(negedge clk);
    check_n("dr_rsp_valid_e13", 32'(rsp_valid_o), 0);
    check_n("dr_idle_e13", 32'(idle_o), 1);
    cyc();
    enable_i = 1'b1; rsp_ready_i = 1'b0;
    @(negedge clk);
    check_n("dr_idle_state_ready", 32'(req_ready_o), 0);

    // Fill 2 FIFO entries + 1 in flight, then clear
    for (int e = 15; e <= 17; e++) begin
      cyc();
      @(negedge clk);
      check_n("cl_fill_ready", 32'(req_ready_o), 1);
    end
    cyc();
    clear_i = 1'b1;
    @(negedge clk);
    check_n("cl_ready_nocredit", 32'(req_ready_o), 0);
    check_n("cl_rsp_valid_before", 32'(rsp_valid_o), 1);
    cyc();
    clear_i = 1'b0; req_valid_i = '0; rsp_ready_i = 1'b1;
    @(negedge clk);
    check_n("cl_rsp_valid_after", 32'(rsp_valid_o), 0);
    check_n("cl_idle_after", 32'(idle_o), 1);
    for (int e = 20; e <= 21; e++) begin
      cyc();
      @(negedge clk);
      check_n("cl_no_stale", 32'(rsp_valid_o), 0);
    end

    // Clear beats issue; pointer survives clear
    cyc();
    req_valid_i = 3'b111; clear_i = 1'b1;
    @(negedge clk);
    check_n("cl_wins_issue", 32'(req_ready_o), 0);
    cyc();
    clear_i = 1'b0;
    @(negedge clk);
    check_n("cl_idle_ready", 32'(req_ready_o), 0);
    cyc();
    @(negedge clk);
    check_n("cl_ptr_kept", 32'(req_ready_o), 3'b010);
    cyc();
    @(negedge clk);
    check_n("cl_next_grant", 32'(req_ready_o), 3'b100);

    // Reset mid-stream
    cyc();
    rst_ni = 1'b0;
    cyc();
    rst_ni = 1'b1;
    @(negedge clk);
    reset_outputs("mrst");
    cyc();
    @(negedge clk);
    check_n("mrst_first_grant", 32'(req_ready_o), 3'b001);

    cyc();
    req_valid_i = '0; enable_i = 1'b0;
    cyc(); cyc(); cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/redmule_castin_arbiter.md
Name: redmule_castin_arbiter

Overview:
Shares one input-cast datapath (fixed pipeline latency, no internal backpressure) between NUM_REQ streamer channels (X, W, Y loads). Issues requests in round-robin order, tags each in-flight beat with its requester ID, and collects results into a credit-protected output FIFO. Responses are returned in issue order with their ID. Sits between the streamer source channels and the cast datapath, upstream of the engine buffers.

Parameters:
- NUM_REQ, 3, number of requesters (2..4).
- DW, 288, beat width in bits; equals the cast datapath data width.
- PIPE_LAT, 1, cast datapath latency in cycles (0..3); 0 means combinational.
- FIFO_DEPTH, PIPE_LAT+2, result FIFO entries; must be >= PIPE_LAT+1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- clear_i  in  1  synchronous flush.
- enable_i  in  1  permit issuing.
- req_valid_i  in  NUM_REQ  per-requester valid.
- req_ready_o  out  NUM_REQ  per-requester ready (one-hot or zero).
- req_data_i  in  NUM_REQ*DW  per-requester beat.
- req_cast_i  in  NUM_REQ  per-requester cast enable.
- req_fmt_i  in  NUM_REQ*3  per-requester source fp_format_e.
- cast_data_o  out  DW  operand to the cast datapath.
- cast_en_o  out  1  cast select driven to the datapath.
- cast_fmt_o  out  3  src_fmt driven to the datapath.
- cast_result_i  in  DW  datapath result, PIPE_LAT cycles after issue.
- rsp_valid_o  out  1  FIFO head valid.
- rsp_ready_i  in  1  consumer accepts the head.
- rsp_data_o  out  DW  FIFO head data.
- rsp_id_o  out  $clog2(NUM_REQ)  FIFO head requester ID.
- idle_o  out  1  no beats in flight and FIFO empty.

Behaviour:
- Reset (rst_ni=0 at a clock edge) values:
  - FSM=IDLE; RR pointer=NUM_REQ-1, so requester 0 wins first.
  - Tag pipe valids=0; FIFO empty; count=0.
  - All outputs 0, except idle_o=1.
- Issue condition: state==ACTIVE AND enable_i AND any req_valid_i AND credit.
- Credit: fifo_count + inflight + 1 <= FIFO_DEPTH.
  - fifo_count and inflight are registered values.
  - The same-cycle FIFO pop is not counted; this is conservative.
- Grant rule:
  - Grant the first valid requester starting at ptr+1, modulo NUM_REQ.
  - req_ready_o[g]=1 only in an issuing cycle.
  - ptr<=g on issue only.
- Datapath drive:
  - cast_data_o/cast_en_o/cast_fmt_o are muxed from the granted requester.
  - They are 0 when not issuing.
- Tag pipe:
  - Depth PIPE_LAT; each entry holds {valid, id}.
  - Shifts every cycle.
  - Output entry valid pushes {cast_result_i, id} into the FIFO.
  - PIPE_LAT=0: push in the issue cycle itself.
- FIFO:
  - Push and pop in the same cycle are both legal when count is in 1..FIFO_DEPTH.
  - Overflow is impossible by credit; overflow is an assertion failure.
  - rsp_valid_o = count!=0; pop on rsp_valid_o & rsp_ready_i.
- FSM transitions:
  - IDLE: enable_i -> ACTIVE.
  - ACTIVE: !enable_i -> DRAIN; no issue that cycle.
  - DRAIN: no issuing. When inflight==0 and FIFO empty -> IDLE. If enable_i rises first -> ACTIVE.
- idle_o: registered; 1 iff next inflight==0 and next FIFO count==0.
- clear_i (priority below reset, above all else):
  - Empties the tag pipe and FIFO, FSM->IDLE, no issue or pop that cycle.
  - ptr is kept.
  - Beats already in the datapath are discarded via invalidated tags.
- Simultaneous clear_i and issue: clear wins; req_ready_o=0.
- Reset mid-transfer: all state is lost; requesters must re-send.

Optional Feature:
REDMULE_CASTIN_ARB_STATS_EN
- When defined, adds outputs:
  - grant_cnt_o (NUM_REQ*32): per-requester issue counters.
  - stall_cnt_o (32): counts cycles with any req_valid_i in ACTIVE but no credit.
- Counters saturate at 2^32-1 and clear on reset or clear_i.
- When undefined, these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- PIPE_LAT=1; all 3 requesters valid continuously with rsp_ready_i=1 -> grants 0,1,2,0,1,2; rsp_id_o sequence identical, 2 cycles after each issue; one issue per cycle.
- Only requester 2 valid, data 0x..AB with cast=0 -> rsp_data_o=0x..AB returned unchanged (datapath model passthrough), rsp_id_o=2.
- rsp_ready_i=0 held; requester 0 streaming; FIFO_DEPTH=3 -> exactly 3 issues, then req_ready_o=0; no FIFO overflow; releasing ready resumes 1 beat/cycle.
- enable_i drops with 1 beat in flight -> FSM DRAIN, no new grants; idle_o=1 one cycle after the last pop; FSM IDLE.
- clear_i pulsed with 2 FIFO entries and 1 in flight -> next cycle rsp_valid_o=0, idle_o=1, and no stale response appears afterward.
- rst_ni=0 for 1 cycle mid-stream -> all outputs at reset values next cycle; the first grant after re-enable goes to requester 0.
